// File: rtl/alk_alu_status.sv
// alk_alu_status: ALK slice carry/borrow, N/Z/V, shift-link and shift-counter latches with long-literal freeze.
// Build option: define ALK_STICKY_Z_EN to AND-accumulate Z across BCD/subtract cc loads.
module alk_alu_status #(
   parameter int SC_W = 5
) (
   input  logic            clk,
   input  logic            reset_h,
   input  logic            ustep_h,
   input  logic            long_lit_l,
   input  logic            sub_op_h,
   input  logic            shift_op_l,
   input  logic            shl_op_h,
   input  logic            shr_op_h,
   input  logic            bcd_op_l,
   input  logic            alu_cout_h,
   input  logic            alu_dcout_h,
   input  logic            alu_msb_h,
   input  logic            alu_zero_h,
   input  logic            alu_ovf_h,
   input  logic            shl_out_h,
   input  logic            shr_out_h,
   input  logic            cc_ld_h,
   input  logic            sc_ld_h,
   input  logic [SC_W-1:0] sc_in_h,
   output logic            cin_h,
   output logic            link_h,
   output logic            alu_n_h,
   output logic            alu_z_h,
   output logic            alu_v_h,
   output logic            alu_c_h,
   output logic            sc_zero_h,
   output logic            lit_busy_h
);

   typedef enum logic [1:0] {
      LIT_IDLE = 2'd0,
      LIT_BODY = 2'd1,
      LIT_TAIL = 2'd2
   } lit_state_t;

   lit_state_t      lit_state_r;
   logic            lit_busy_r;
   logic            c_r;
   logic            n_r;
   logic            z_r;
   logic            v_r;
   logic            link_r;
   logic            sc_zero_r;
   logic [SC_W-1:0] sc_r;

   logic            frz_s;
   logic            upd_s;
   logic            cin_s;
   logic            c_nxt_s;
   logic            z_nxt_s;
   logic            link_nxt_s;
   logic [SC_W-1:0] sc_nxt_s;

   // Carry latch source: borrow for subtract, then decimal, then shifted-out bit, else binary carry.
   function automatic logic carry_sel(
      input logic sub,
      input logic bcd_l,
      input logic shl,
      input logic shr,
      input logic cout,
      input logic dcout,
      input logic shl_bit,
      input logic shr_bit
   );
      logic r;
      if (sub) begin
         r = ~cout;
      end else if (!bcd_l) begin
         r = dcout;
      end else if (shl) begin
         r = shl_bit;
      end else if (shr) begin
         r = shr_bit;
      end else begin
         r = cout;
      end
      return r;
   endfunction

   // Shift counter next value: load beats decrement, decrement saturates at zero.
   function automatic logic [SC_W-1:0] sc_step(
      input logic [SC_W-1:0] sc,
      input logic            ld,
      input logic [SC_W-1:0] ld_val,
      input logic            shift_l
   );
      logic [SC_W-1:0] r;
      if (ld) begin
         r = ld_val;
      end else if (!shift_l && (sc != {SC_W{1'b0}})) begin
         r = sc - {{(SC_W-1){1'b0}}, 1'b1};
      end else begin
         r = sc;
      end
      return r;
   endfunction

   // Freeze window and update qualifier.
   always_comb begin
      frz_s = lit_busy_r | ~long_lit_l;
      upd_s = ustep_h & ~frz_s;
   end

   // Carry-in for the ALU op issued in the current microcycle.
   always_comb begin
      cin_s = 1'b0;
      if (frz_s) begin
         cin_s = 1'b0;
      end else if (sub_op_h) begin
         cin_s = 1'b1;
      end else if (!bcd_op_l) begin
         cin_s = c_r;
      end else if (!shift_op_l) begin
         cin_s = c_r;
      end else begin
         cin_s = 1'b0;
      end
   end

   // Next-state values for the condition, link and counter latches.
   always_comb begin
      c_nxt_s = carry_sel(sub_op_h, bcd_op_l, shl_op_h, shr_op_h,
                          alu_cout_h, alu_dcout_h, shl_out_h, shr_out_h);
`ifdef ALK_STICKY_Z_EN
      if (!bcd_op_l || sub_op_h) begin
         z_nxt_s = z_r & alu_zero_h;
      end else begin
         z_nxt_s = alu_zero_h;
      end
`else
      z_nxt_s = alu_zero_h;
`endif
      if (shl_op_h) begin
         link_nxt_s = shl_out_h;
      end else if (shr_op_h) begin
         link_nxt_s = shr_out_h;
      end else begin
         link_nxt_s = link_r;
      end
      sc_nxt_s = sc_step(sc_r, sc_ld_h, sc_in_h, shift_op_l);
   end

   // Long-literal sequencer; busy flag is registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset_h) begin
         lit_state_r <= LIT_IDLE;
         lit_busy_r  <= 1'b0;
      end else if (ustep_h) begin
         case (lit_state_r)
            LIT_IDLE: begin
               if (!long_lit_l) begin
                  lit_state_r <= LIT_BODY;
                  lit_busy_r  <= 1'b1;
               end else begin
                  lit_state_r <= LIT_IDLE;
                  lit_busy_r  <= 1'b0;
               end
            end
            LIT_BODY: begin
               lit_state_r <= long_lit_l ? LIT_TAIL : LIT_BODY;
               lit_busy_r  <= 1'b1;
            end
            LIT_TAIL: begin
               if (!long_lit_l) begin
                  lit_state_r <= LIT_BODY;
                  lit_busy_r  <= 1'b1;
               end else begin
                  lit_state_r <= LIT_IDLE;
                  lit_busy_r  <= 1'b0;
               end
            end
            default: begin
               lit_state_r <= LIT_IDLE;
               lit_busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Condition, link and shift-counter latches; all hold while frozen or without a microcycle.
   always_ff @(posedge clk) begin
      if (reset_h) begin
         c_r       <= 1'b0;
         n_r       <= 1'b0;
         z_r       <= 1'b0;
         v_r       <= 1'b0;
         link_r    <= 1'b0;
         sc_r      <= {SC_W{1'b0}};
         sc_zero_r <= 1'b1;
      end else if (upd_s) begin
         if (cc_ld_h) begin
            n_r <= alu_msb_h;
            v_r <= alu_ovf_h;
            z_r <= z_nxt_s;
            c_r <= c_nxt_s;
         end
         link_r    <= link_nxt_s;
         sc_r      <= sc_nxt_s;
         sc_zero_r <= (sc_nxt_s == {SC_W{1'b0}});
      end
   end

   assign cin_h      = cin_s;
   assign link_h     = link_r;
   assign alu_n_h    = n_r;
   assign alu_z_h    = z_r;
   assign alu_v_h    = v_r;
   assign alu_c_h    = c_r;
   assign sc_zero_h  = sc_zero_r;
   assign lit_busy_h = lit_busy_r;

endmodule

// File: tb/tb_alk_alu_status.sv
// Self-checking bench for alk_alu_status: directed test-plan steps followed by randomized cycles
// compared against a behavioural reference model.
module tb_alk_alu_status;

   localparam int SC_W = 5;
`ifdef ALK_STICKY_Z_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset_h, ustep_h, long_lit_l, sub_op_h, shift_op_l, shl_op_h, shr_op_h, bcd_op_l;
   logic            alu_cout_h, alu_dcout_h, alu_msb_h, alu_zero_h, alu_ovf_h, shl_out_h, shr_out_h;
   logic            cc_ld_h, sc_ld_h;
   logic [SC_W-1:0] sc_in_h;
   logic            cin_h, link_h, alu_n_h, alu_z_h, alu_v_h, alu_c_h, sc_zero_h, lit_busy_h;

   int tests = 0;
   int fails = 0;

   // Reference model state
   bit m_c, m_n, m_z, m_v, m_link, m_busy, m_in_lit;
   int m_sc;

   alk_alu_status #(.SC_W(SC_W)) dut (
      .clk(clk), .reset_h(reset_h), .ustep_h(ustep_h), .long_lit_l(long_lit_l),
      .sub_op_h(sub_op_h), .shift_op_l(shift_op_l), .shl_op_h(shl_op_h), .shr_op_h(shr_op_h),
      .bcd_op_l(bcd_op_l), .alu_cout_h(alu_cout_h), .alu_dcout_h(alu_dcout_h),
      .alu_msb_h(alu_msb_h), .alu_zero_h(alu_zero_h), .alu_ovf_h(alu_ovf_h),
      .shl_out_h(shl_out_h), .shr_out_h(shr_out_h), .cc_ld_h(cc_ld_h), .sc_ld_h(sc_ld_h),
      .sc_in_h(sc_in_h), .cin_h(cin_h), .link_h(link_h), .alu_n_h(alu_n_h), .alu_z_h(alu_z_h),
      .alu_v_h(alu_v_h), .alu_c_h(alu_c_h), .sc_zero_h(sc_zero_h), .lit_busy_h(lit_busy_h)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_cin();
      bit frz = m_busy | ~long_lit_l;
      if (frz) return 1'b0;
      if (sub_op_h) return 1'b1;
      if (!bcd_op_l || !shift_op_l) return m_c;
      return 1'b0;
   endfunction

   function automatic void model_update();
      bit frz;
      bit was_lit;
      if (reset_h) begin
         {m_c, m_n, m_z, m_v, m_link, m_busy, m_in_lit} = 7'd0;
         m_sc = 0;
         return;
      end
      if (!ustep_h) return;
      frz = m_busy | ~long_lit_l;
      if (!frz) begin
         if (cc_ld_h) begin
            m_n = alu_msb_h;
            m_v = alu_ovf_h;
            if (STICKY && (!bcd_op_l || sub_op_h)) m_z = m_z & alu_zero_h;
            else m_z = alu_zero_h;
            if (sub_op_h) m_c = ~alu_cout_h;
            else if (!bcd_op_l) m_c = alu_dcout_h;
            else if (shl_op_h) m_c = shl_out_h;
            else if (shr_op_h) m_c = shr_out_h;
            else m_c = alu_cout_h;
         end
         if (shl_op_h) m_link = shl_out_h;
         else if (shr_op_h) m_link = shr_out_h;
         if (sc_ld_h) m_sc = int'(sc_in_h);
         else if (!shift_op_l && m_sc > 0) m_sc = m_sc - 1;
      end
      // The window stays open one step after the last long-literal cycle.
      was_lit  = m_in_lit;
      m_in_lit = ~long_lit_l;
      m_busy   = ~long_lit_l | was_lit;
   endfunction

   task automatic step(input string tag);
      bit exp_cin;
      #2;
      exp_cin = model_cin();
      chk({tag, ".cin"}, {7'd0, cin_h}, {7'd0, exp_cin});
      @(posedge clk);
      model_update();
      #1;
      chk({tag, ".regs"},
          {1'b0, alu_n_h, alu_z_h, alu_v_h, alu_c_h, link_h, sc_zero_h, lit_busy_h},
          {1'b0, m_n, m_z, m_v, m_c, m_link, (m_sc == 0), m_busy});
   endtask

   task automatic set_idle();
      reset_h = 1'b0; ustep_h = 1'b1; long_lit_l = 1'b1;
      sub_op_h = 1'b0; shift_op_l = 1'b1; shl_op_h = 1'b0; shr_op_h = 1'b0; bcd_op_l = 1'b1;
      alu_cout_h = 1'b0; alu_dcout_h = 1'b0; alu_msb_h = 1'b0; alu_zero_h = 1'b0; alu_ovf_h = 1'b0;
      shl_out_h = 1'b0; shr_out_h = 1'b0; cc_ld_h = 1'b0; sc_ld_h = 1'b0; sc_in_h = 5'd0;
   endtask

   initial begin
      set_idle();
      reset_h = 1'b1;
      step("rst0");
      step("rst1");
      reset_h = 1'b0;
      step("idle");
      chk("idle.ncz_v", {4'd0, alu_n_h, alu_z_h, alu_v_h, alu_c_h}, 8'd0);
      chk("idle.flags", {5'd0, link_h, sc_zero_h, lit_busy_h}, 8'b0000_0010);
      chk("idle.cin", {7'd0, cin_h}, 8'd0);

      // Subtract with no carry out: carry-in forced, borrow latched
      sub_op_h = 1'b1; alu_cout_h = 1'b0; cc_ld_h = 1'b1;
      #2 chk("sub.cin_now", {7'd0, cin_h}, 8'd1);
      step("sub");
      chk("sub.borrow", {7'd0, alu_c_h}, 8'd1);

      // Multi-step left shift under counter control
      set_idle();
      sc_ld_h = 1'b1; sc_in_h = 5'd3;
      step("scld3");
      chk("scld3.nz", {7'd0, sc_zero_h}, 8'd0);
      sc_ld_h = 1'b0; shl_op_h = 1'b1; shift_op_l = 1'b0;
      shl_out_h = 1'b1; step("shl1");
      shl_out_h = 1'b0; step("shl2");
      chk("shl2.nz", {7'd0, sc_zero_h}, 8'd0);
      shl_out_h = 1'b1; step("shl3");
      chk("shl3.zero", {6'd0, sc_zero_h, link_h}, 8'b0000_0011);
      step("shl4");
      chk("shl4.sat", {7'd0, sc_zero_h}, 8'd1);

      // Long literal freeze window: cc loads ignored, cin held low
      set_idle();
      cc_ld_h = 1'b1; alu_cout_h = 1'b0;
      step("c_clear");
      long_lit_l = 1'b0; alu_cout_h = 1'b1;
      step("lit1");
      chk("lit1.busy", {6'd0, lit_busy_h, alu_c_h}, 8'b0000_0010);
      step("lit2");
      long_lit_l = 1'b1;
      step("tail");
      chk("tail.busy", {6'd0, lit_busy_h, alu_c_h}, 8'b0000_0010);
      step("post");
      chk("post.idle", {7'd0, lit_busy_h}, 8'd0);

      // Load beats simultaneous decrement
      set_idle();
      sc_ld_h = 1'b1; sc_in_h = 5'd5; shift_op_l = 1'b0;
      step("ld_vs_dec");
      sc_ld_h = 1'b0;
      for (int i = 0; i < 4; i++) step("dec5");
      chk("dec5.nz", {7'd0, sc_zero_h}, 8'd0);
      step("dec5_last");
      chk("dec5.zero", {7'd0, sc_zero_h}, 8'd1);

      // Reset in the middle of a literal
      set_idle();
      long_lit_l = 1'b0;
      step("lit_pre_rst");
      reset_h = 1'b1;
      step("lit_rst");
      chk("lit_rst.idle", {7'd0, lit_busy_h}, 8'd0);

      // Z behaviour across successive BCD loads
      set_idle();
      cc_ld_h = 1'b1; alu_zero_h = 1'b1;
      step("z_pre");
      bcd_op_l = 1'b0;
      alu_zero_h = 1'b1; step("zbcd1");
      chk("zbcd1", {7'd0, alu_z_h}, 8'd1);
      alu_zero_h = 1'b0; step("zbcd2");
      chk("zbcd2", {7'd0, alu_z_h}, 8'd0);
      alu_zero_h = 1'b1; step("zbcd3");
      chk("zbcd3", {7'd0, alu_z_h}, STICKY ? 8'd0 : 8'd1);

      // Randomized cycles against the model
      for (int i = 0; i < 400; i++) begin
         reset_h     = ($urandom_range(0, 31) == 0);
         ustep_h     = ($urandom_range(0, 3) != 0);
         long_lit_l  = ($urandom_range(0, 5) != 0);
         sub_op_h    = ($urandom_range(0, 3) == 0);
         shift_op_l  = ($urandom_range(0, 2) != 0);
         shl_op_h    = ($urandom_range(0, 2) == 0);
         shr_op_h    = ($urandom_range(0, 2) == 0);
         bcd_op_l    = ($urandom_range(0, 3) != 0);
         alu_cout_h  = ($urandom_range(0, 1) != 0);
         alu_dcout_h = ($urandom_range(0, 1) != 0);
         alu_msb_h   = ($urandom_range(0, 1) != 0);
         alu_zero_h  = ($urandom_range(0, 2) != 0);
         alu_ovf_h   = ($urandom_range(0, 1) != 0);
         shl_out_h   = ($urandom_range(0, 1) != 0);
         shr_out_h   = ($urandom_range(0, 1) != 0);
         cc_ld_h     = ($urandom_range(0, 1) != 0);
         sc_ld_h     = ($urandom_range(0, 7) == 0);
         sc_in_h     = 5'($urandom_range(0, 31));
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alk_alu_status.md
Name: alk_alu_status

Overview:
- Downstream of the ALK ALU-op decoder, inside the DC615 ALK datapath slice.
- Consumes decoded op strobes (sub/shift/shl/shr/bcd) plus slice result flags.
- Holds the carry/borrow latch, N/Z/V latches, the shift-link bit and the multi-step shift counter.
- Sequences the long-literal freeze window; drives carry-in and link-in back to the ALU for the next microcycle.

Parameters:
- SC_W, 5, width of shift counter (max 31 steps).

Ports:
- clk  in  1  microcycle clock.
- reset_h  in  1  synchronous, active-high reset.
- ustep_h  in  1  microcycle enable; all registers hold when 0.
- long_lit_l  in  1  long-literal cycle, active low.
- sub_op_h  in  1  decoded subtract.
- shift_op_l  in  1  decoded shift, active low.
- shl_op_h  in  1  decoded shift left.
- shr_op_h  in  1  decoded shift right.
- bcd_op_l  in  1  decoded BCD op, active low.
- alu_cout_h  in  1  binary carry out of MSB.
- alu_dcout_h  in  1  decimal carry out of top digit.
- alu_msb_h  in  1  result sign.
- alu_zero_h  in  1  result zero.
- alu_ovf_h  in  1  result overflow.
- shl_out_h  in  1  bit shifted out, left shift.
- shr_out_h  in  1  bit shifted out, right shift.
- cc_ld_h  in  1  microcode strobe to load N/Z/V/C.
- sc_ld_h  in  1  load shift counter.
- sc_in_h  in  SC_W  shift count value.
- cin_h  out  1  carry into next ALU op (combinational).
- link_h  out  1  shift-in bit for next shift.
- alu_n_h, alu_z_h, alu_v_h, alu_c_h  out  1 each  latched condition bits.
- sc_zero_h  out  1  shift counter == 0.
- lit_busy_h  out  1  long-literal freeze window active.

Behaviour:
- Clock and reset:
  - Single clock, synchronous active-high reset; reset overrides ustep_h.
  - Reset values: C=N=V=0, Z=0, link=0, sc=0, FSM=IDLE. Hence sc_zero_h=1 and lit_busy_h=0.
- Freeze:
  - frz = lit_busy_h | ~long_lit_l.
  - While frz=1: cc_ld_h ignored, link held, shift counter held (sc_ld_h also ignored).
- Long-literal FSM (advances only when ustep_h=1):
  - IDLE -> LIT when long_lit_l=0.
  - LIT stays in LIT while long_lit_l=0; LIT -> TAIL when long_lit_l=1.
  - TAIL -> LIT if long_lit_l=0, else TAIL -> IDLE.
  - lit_busy_h=1 in LIT and TAIL.
  - Reset mid-literal returns to IDLE immediately.
- cin_h (combinational):
  - 0 when frz=1.
  - Else 1 when sub_op_h=1 (two's-complement add).
  - Else C when bcd_op_l=0.
  - Else C when shift_op_l=0 (rotate-through-carry).
  - Else 0.
- Condition load (cc_ld_h=1, frz=0, ustep_h=1):
  - N <= alu_msb_h; V <= alu_ovf_h; Z <= alu_zero_h.
  - C <= ~alu_cout_h if sub (borrow); alu_dcout_h if bcd; shl_out_h if shl; shr_out_h if shr; else alu_cout_h.
  - Priority: sub > bcd > shl > shr.
- Link: on ustep_h with frz=0, link <= shl_out_h if shl_op_h, shr_out_h if shr_op_h, else held. Updated independent of cc_ld_h.
- Shift counter (frz=0, ustep_h=1):
  - sc_ld_h=1 loads sc_in_h; load wins over a simultaneous decrement.
  - Else decrement by 1 when shift_op_l=0 and sc!=0.
  - Saturates at 0; never wraps.
- sc_zero_h registered-derived: reflects the current sc value, no extra latency.
- Output latency: all latched outputs visible the cycle after the capturing edge. cin_h reacts to inputs in the same cycle.

Optional Feature:
- ALK_STICKY_Z_EN:
  - Defined: on a cc load while bcd_op_l=0 or sub_op_h=1, Z <= Z & alu_zero_h, giving multi-precision zero detection across successive microcycles. Other ops load Z directly.
  - Undefined: Z <= alu_zero_h always.

Test Plan:
- Reset then idle -> C=N=Z=V=0, link_h=0, sc_zero_h=1, lit_busy_h=0, cin_h=0.
- sub_op_h=1, alu_cout_h=0, cc_ld_h=1 -> cin_h=1 that cycle; next cycle alu_c_h=1 (borrow).
- sc_ld_h=1, sc_in_h=3; then 3 cycles shl_op_h=1, shift_op_l=0, shl_out_h=1,0,1 -> sc 3,2,1,0, sc_zero_h=1 after third, link_h=1; a 4th shift leaves sc=0.
- long_lit_l=0 for 2 cycles with cc_ld_h=1, alu_cout_h=1 -> C unchanged, lit_busy_h=1 for 3 cycles (LIT,LIT,TAIL), cin_h=0 throughout, then IDLE.
- sc_ld_h=1, sc_in_h=5 simultaneous with a shift cycle -> sc=5; reset asserted in LIT -> next cycle IDLE, lit_busy_h=0.
- With ALK_STICKY_Z_EN: bcd cc loads with alu_zero_h=1 then 0 then 1 -> Z=1,0,0; without the macro -> Z=1,0,1.
